// File: rtl/status_led_pwm_if.sv
// Config write port for status_led_pwm: one-cycle strobe, LED index and
// packed {mode[1:0], colour[2:0] (b,g,r), duty[PWM_BITS-1:0]}.
interface status_led_pwm_if #(
  parameter int unsigned NUM_LEDS = 2,
  parameter int unsigned PWM_BITS = 8
);
  localparam int unsigned AW = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1;

  logic                wr_en;
  logic [AW-1:0]       wr_addr;
  logic [PWM_BITS+4:0] wr_data;

  modport master (output wr_en, output wr_addr, output wr_data);
  modport slave  (input  wr_en, input  wr_addr, input  wr_data);
endinterface

// File: rtl/status_led_pwm.sv
// Multi-LED RGB status driver: per-LED duty/colour/mode with shared blink and breathe
// generators. Define STATUS_LED_BREATHE_EN to build the breathe generator (else mode 11 = steady).
module status_led_pwm #(
  parameter int unsigned NUM_LEDS        = 2,
  parameter int unsigned PWM_BITS        = 8,
  parameter int unsigned PRESCALE        = 64,
  parameter int unsigned BLINK_PERIODS   = 1526,
  parameter int unsigned BREATHE_PERIODS = 6
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic [NUM_LEDS-1:0]   status_in,
  status_led_pwm_if.slave       cfg,
  output logic [3*NUM_LEDS-1:0] rgb_led,
  output logic                  period_stb
);
  localparam int unsigned AW = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1;
  localparam int unsigned CW = PWM_BITS + 5;
  localparam int unsigned PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int unsigned BW = (BLINK_PERIODS > 1) ? $clog2(BLINK_PERIODS) : 1;

  typedef enum logic [1:0] {
    MODE_OFF     = 2'b00,
    MODE_STEADY  = 2'b01,
    MODE_BLINK   = 2'b10,
    MODE_BREATHE = 2'b11
  } mode_e;

  typedef enum logic {PH_ON = 1'b0, PH_OFF = 1'b1} phase_e;

  logic [PW-1:0]         presc_q, presc_d;
  logic [PWM_BITS-1:0]   cnt_q, cnt_d;
  logic                  tick, wrap;
  logic [BW-1:0]         blink_cnt_q, blink_cnt_d;
  phase_e                phase_q, phase_d;
  logic [CW-1:0]         pending_q [NUM_LEDS];
  logic [CW-1:0]         pending_d [NUM_LEDS];
  logic [CW-1:0]         active_q  [NUM_LEDS];
  logic [CW-1:0]         active_d  [NUM_LEDS];
  logic [3*NUM_LEDS-1:0] rgb_q, rgb_d;

  always_comb begin
    tick        = (presc_q == PW'(PRESCALE - 1));
    wrap        = tick && (cnt_q == '1);
    presc_d     = tick ? '0 : presc_q + PW'(1);
    cnt_d       = tick ? cnt_q + PWM_BITS'(1) : cnt_q;
    blink_cnt_d = blink_cnt_q;
    phase_d     = phase_q;
    if (wrap) begin
      if (blink_cnt_q == BW'(BLINK_PERIODS - 1)) begin
        blink_cnt_d = '0;
        phase_d     = (phase_q == PH_ON) ? PH_OFF : PH_ON;
      end else begin
        blink_cnt_d = blink_cnt_q + BW'(1);
      end
    end
  end

  // pending_d already holds a same-cycle write, so a write on the wrap cycle lands in active directly
  always_comb begin
    for (int unsigned i = 0; i < NUM_LEDS; i++) begin
      pending_d[i] = (cfg.wr_en && (cfg.wr_addr == AW'(i))) ? cfg.wr_data : pending_q[i];
      active_d[i]  = wrap ? pending_d[i] : active_q[i];
    end
  end

`ifdef STATUS_LED_BREATHE_EN
  localparam int unsigned RW = (BREATHE_PERIODS > 1) ? $clog2(BREATHE_PERIODS) : 1;

  typedef enum logic {DIR_UP = 1'b0, DIR_DOWN = 1'b1} dir_e;

  logic [RW-1:0]       brth_cnt_q, brth_cnt_d;
  logic                brth_step;
  dir_e                dir_q, dir_d;
  logic [PWM_BITS-1:0] level_q, level_d;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      brth_cnt_q <= '0;
      dir_q      <= DIR_UP;
      level_q    <= '0;
    end else begin
      brth_cnt_q <= brth_cnt_d;
      dir_q      <= dir_d;
      level_q    <= level_d;
    end
  end

  // Direction flips on the step that reaches an endpoint without moving, holding it one step
  always_comb begin
    brth_step  = 1'b0;
    brth_cnt_d = brth_cnt_q;
    dir_d      = dir_q;
    if (wrap) begin
      if (brth_cnt_q == RW'(BREATHE_PERIODS - 1)) begin
        brth_cnt_d = '0;
        brth_step  = 1'b1;
      end else begin
        brth_cnt_d = brth_cnt_q + RW'(1);
      end
    end
    if (brth_step) begin
      case (dir_q)
        DIR_UP:   if (level_q == '1) dir_d = DIR_DOWN;
        DIR_DOWN: if (level_q == '0) dir_d = DIR_UP;
        default:  dir_d = DIR_UP;
      endcase
    end
  end

  always_comb begin
    level_d = level_q;
    if (brth_step) begin
      case (dir_q)
        DIR_UP:   if (level_q != '1) level_d = level_q + PWM_BITS'(1);
        DIR_DOWN: if (level_q != '0) level_d = level_q - PWM_BITS'(1);
        default:  level_d = level_q;
      endcase
    end
  end
`endif

  always_comb begin
    mode_e               mode;
    logic [2:0]          colour;
    logic [PWM_BITS-1:0] duty;
    logic [PWM_BITS-1:0] eff;
    rgb_d = '0;
    for (int unsigned i = 0; i < NUM_LEDS; i++) begin
      mode   = mode_e'(active_q[i][CW-1 -: 2]);
      colour = active_q[i][PWM_BITS +: 3];
      duty   = active_q[i][PWM_BITS-1:0];
      case (mode)
        MODE_STEADY:  eff = duty;
        MODE_BLINK:   eff = (phase_q == PH_ON) ? duty : '0;
`ifdef STATUS_LED_BREATHE_EN
        MODE_BREATHE: eff = (duty < level_q) ? duty : level_q;
`else
        MODE_BREATHE: eff = duty;
`endif
        default:      eff = '0;
      endcase
      for (int unsigned c = 0; c < 3; c++) begin
        rgb_d[3*i + c] = (cnt_q < eff) && colour[c] && status_in[i];
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      presc_q     <= '0;
      cnt_q       <= '0;
      blink_cnt_q <= '0;
      phase_q     <= PH_ON;
      rgb_q       <= '0;
      for (int unsigned i = 0; i < NUM_LEDS; i++) begin
        pending_q[i] <= '0;
        active_q[i]  <= '0;
      end
    end else begin
      presc_q     <= presc_d;
      cnt_q       <= cnt_d;
      blink_cnt_q <= blink_cnt_d;
      phase_q     <= phase_d;
      rgb_q       <= rgb_d;
      for (int unsigned i = 0; i < NUM_LEDS; i++) begin
        pending_q[i] <= pending_d[i];
        active_q[i]  <= active_d[i];
      end
    end
  end

  assign rgb_led    = rgb_q;
  assign period_stb = wrap;

endmodule

// File: tb/tb_status_led_pwm.sv
// Directed bench for status_led_pwm: 2 LEDs, 4-bit PWM, prescale 1, blink 2, breathe 1.
module tb_status_led_pwm;
  localparam int unsigned NL = 2;
  localparam int unsigned PB = 4;

  logic       clk;
  logic       resetn;
  logic [1:0] status_in;
  logic [5:0] rgb_led;
  logic       period_stb;

  int total = 0;
  int bad   = 0;
  int cyc;

  int         meas_hi [64];
  int         meas_p0;
  logic [5:0] meas_other;
  bit         meas_partial;

  status_led_pwm_if #(.NUM_LEDS(NL), .PWM_BITS(PB)) cfg ();

  status_led_pwm #(
    .NUM_LEDS(NL), .PWM_BITS(PB), .PRESCALE(1), .BLINK_PERIODS(2), .BREATHE_PERIODS(1)
  ) dut (
    .clk(clk), .resetn(resetn), .status_in(status_in), .cfg(cfg),
    .rgb_led(rgb_led), .period_stb(period_stb)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Edges since reset release; at each sample cnt == cyc % 16
  always @(posedge clk or negedge resetn) begin
    if (!resetn) cyc <= 0;
    else         cyc <= cyc + 1;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  function automatic int lvl_at(input int p);
    int t;
    t = p % 32;
    return (t < 16) ? t : 31 - t;
  endfunction

  function automatic bit blink_on(input int p);
    return ((p / 2) % 2) == 0;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic to_phase(input int ph);
    for (int k = 0; k < 17; k++) begin
      step();
      if ((cyc % 16) == ph) break;
    end
  endtask

  task automatic cfg_write(input logic addr, input logic [8:0] data);
    cfg.wr_en   = 1'b1;
    cfg.wr_addr = addr;
    cfg.wr_data = data;
    step();
    cfg.wr_en   = 1'b0;
  endtask

  // Count samples per PWM period where all watched bits are high
  task automatic measure(input int nper, input logic [5:0] watch);
    to_phase(1);
    meas_p0      = (cyc - 1) / 16;
    meas_other   = '0;
    meas_partial = 1'b0;
    for (int p = 0; p < nper; p++) begin
      meas_hi[p] = 0;
      for (int s = 0; s < 16; s++) begin
        if (p != 0 || s != 0) step();
        if ((rgb_led & watch) == watch)  meas_hi[p]++;
        else if ((rgb_led & watch) != 0) meas_partial = 1'b1;
        meas_other |= rgb_led & ~watch;
      end
    end
  endtask

  task automatic test_reset();
    resetn      = 1'b1;
    status_in   = 2'b00;
    cfg.wr_en   = 1'b0;
    cfg.wr_addr = 1'b0;
    cfg.wr_data = '0;
    #2 resetn = 1'b0;
    #1;
    total++;
    if (rgb_led !== 6'b0) begin bad++; $display("FAIL rst_rgb: got %b want 000000", rgb_led); end
    total++;
    if (period_stb !== 1'b0) begin bad++; $display("FAIL rst_stb: got %b want 0", period_stb); end
    step(); step(); step();
    resetn = 1'b1;
    for (int k = 0; k < 100; k++) begin
      step();
      total++;
      if (rgb_led !== 6'b0) begin bad++; $display("FAIL idle_rgb: cyc %0d got %b want 000000", cyc, rgb_led); end
      total++;
      if (period_stb !== ((cyc % 16) == 15)) begin
        bad++; $display("FAIL idle_stb: cyc %0d got %b want %0d", cyc, period_stb, (cyc % 16) == 15);
      end
    end
  endtask

  task automatic test_steady();
    status_in = 2'b01;
    cfg_write(1'b0, {2'b01, 3'b001, 4'd5});
    measure(2, 6'b000001);
    for (int p = 0; p < 2; p++) begin
      total++;
      if (meas_hi[p] !== 5) begin bad++; $display("FAIL steady_hi: got %0d want 5", meas_hi[p]); end
    end
    total++;
    if (meas_other !== 6'b0) begin bad++; $display("FAIL steady_other: got %b want 000000", meas_other); end
    to_phase(2);
    total++;
    if (rgb_led[0] !== 1'b1) begin bad++; $display("FAIL status_pre: got %b want 1", rgb_led[0]); end
    status_in = 2'b00;
    step();
    total++;
    if (rgb_led[0] !== 1'b0) begin bad++; $display("FAIL status_drop: got %b want 0", rgb_led[0]); end
  endtask

  task automatic test_blink();
    int exp_hi;
    status_in = 2'b10;
    cfg_write(1'b1, {2'b10, 3'b111, 4'd15});
    measure(6, 6'b111000);
    for (int p = 0; p < 6; p++) begin
      exp_hi = blink_on(meas_p0 + p) ? 15 : 0;
      total++;
      if (meas_hi[p] !== exp_hi) begin
        bad++; $display("FAIL blink_hi: period %0d got %0d want %0d", meas_p0 + p, meas_hi[p], exp_hi);
      end
    end
    total++;
    if (meas_partial !== 1'b0) begin bad++; $display("FAIL blink_colour: got partial=%0d want 0", meas_partial); end
    total++;
    if (meas_other !== 6'b0) begin bad++; $display("FAIL blink_other: got %b want 000000", meas_other); end
  endtask

  task automatic test_write_timing();
    int hi;
    status_in   = 2'b01;
    cfg.wr_addr = 1'b0;
    cfg.wr_data = {2'b01, 3'b001, 4'd12};
    to_phase(1);
    hi = 0;
    for (int s = 0; s < 16; s++) begin
      if (s != 0) step();
      if (rgb_led[0]) hi++;
      cfg.wr_en = ((cyc % 16) == 3);
    end
    cfg.wr_en = 1'b0;
    total++;
    if (hi !== 5) begin bad++; $display("FAIL midwrite_cur: got %0d want 5", hi); end
    measure(1, 6'b000001);
    total++;
    if (meas_hi[0] !== 12) begin bad++; $display("FAIL midwrite_next: got %0d want 12", meas_hi[0]); end

    to_phase(15);
    cfg_write(1'b0, {2'b01, 3'b001, 4'd9});
    measure(1, 6'b000001);
    total++;
    if (meas_hi[0] !== 9) begin bad++; $display("FAIL wrapwrite: got %0d want 9", meas_hi[0]); end

    status_in = 2'b11;
    cfg_write(1'b1, 9'h000);
    measure(1, 6'b000001);
    total++;
    if (meas_hi[0] !== 9) begin bad++; $display("FAIL addr_keep: got %0d want 9", meas_hi[0]); end
    total++;
    if (meas_other !== 6'b0) begin bad++; $display("FAIL addr_led1_off: got %b want 000000", meas_other); end
  endtask

  task automatic test_breathe();
    int exp_hi;
    int lv;
    status_in = 2'b01;
    for (int d = 0; d < 2; d++) begin
      cfg_write(1'b0, {2'b11, 3'b001, (d == 0) ? 4'd15 : 4'd8});
      measure(34, 6'b000001);
      for (int p = 0; p < 34; p++) begin
        lv = lvl_at(meas_p0 + p);
`ifdef STATUS_LED_BREATHE_EN
        exp_hi = (d == 0) ? ((lv < 15) ? lv : 15) : ((lv < 8) ? lv : 8);
`else
        exp_hi = (d == 0) ? 15 : 8;
        if (lv < 0) exp_hi = 0;
`endif
        total++;
        if (meas_hi[p] !== exp_hi) begin
          bad++; $display("FAIL breathe_hi: duty_set %0d period %0d got %0d want %0d", d, meas_p0 + p, meas_hi[p], exp_hi);
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    status_in = 2'b01;
    cfg_write(1'b0, {2'b01, 3'b001, 4'd12});
    measure(1, 6'b000001);
    total++;
    if (meas_hi[0] !== 12) begin bad++; $display("FAIL prereset_hi: got %0d want 12", meas_hi[0]); end
    to_phase(3);
    total++;
    if (rgb_led[0] !== 1'b1) begin bad++; $display("FAIL prereset_lit: got %b want 1", rgb_led[0]); end
    #2 resetn = 1'b0;
    #1;
    total++;
    if (rgb_led !== 6'b0) begin bad++; $display("FAIL async_rst_rgb: got %b want 000000", rgb_led); end
    total++;
    if (period_stb !== 1'b0) begin bad++; $display("FAIL async_rst_stb: got %b want 0", period_stb); end
    step(); step();
    resetn = 1'b1;
    for (int k = 0; k < 20; k++) begin
      step();
      total++;
      if (period_stb !== ((cyc % 16) == 15)) begin
        bad++; $display("FAIL restart_stb: cyc %0d got %b want %0d", cyc, period_stb, (cyc % 16) == 15);
      end
    end
    measure(2, 6'b000001);
    for (int p = 0; p < 2; p++) begin
      total++;
      if (meas_hi[p] !== 0) begin bad++; $display("FAIL cleared_hi: got %0d want 0", meas_hi[p]); end
    end
    total++;
    if (meas_other !== 6'b0) begin bad++; $display("FAIL cleared_other: got %b want 000000", meas_other); end
  endtask

  initial begin
    test_reset();
    test_steady();
    test_blink();
    test_write_timing();
    test_breathe();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
